// File: rtl/rat_flag_unit.sv
// rat_flag_unit -- RAT CPU status flags (C, Z, I), interrupt shadow copies of C/Z,
// INTR synchroniser and gated interrupt request to the control unit.
//
// Build option: define RAT_INT_EDGE_EN to get edge-triggered interrupts. A rising
// edge of the synchronised INTR is latched as pending until the control unit
// acknowledges it. Without the macro the block is level-sensitive: the request
// follows the synchronised INTR and is lost if INTR drops while interrupts are masked.
//
// SYNC_STAGES is the depth of the INTR synchroniser. Legal values are 2..4.

module rat_flag_unit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic C_IN,
    input  logic Z_IN,
    input  logic FLG_C_LD,
    input  logic FLG_Z_LD,
    input  logic FLG_C_SET,
    input  logic FLG_C_CLR,
    input  logic FLG_RESTORE,
    input  logic I_SET,
    input  logic I_CLR,
    input  logic INT_ACK,
    input  logic INTR,
    output logic C_FLAG,
    output logic Z_FLAG,
    output logic I_FLAG,
    output logic INT_REQ
);

    // Interrupt-entry tracking: IDLE until an acknowledged request, IN_ISR until RETx
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_IN_ISR = 1'b1;

    logic                   c_q, c_d;
    logic                   z_q, z_d;
    logic                   i_q, i_d;
    logic                   sh_c_q, sh_c_d;
    logic                   sh_z_q, sh_z_d;
    logic                   int_req_q, int_req_d;
    logic [0:0]             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   intr_s;
    logic                   ack_live;
    logic                   req_src;

    // ------------------------------------------------------------------
    // INTR synchroniser: stage 0 samples the pin, each later stage samples
    // its predecessor. The last stage is the only one the logic may use.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_d[gi] = INTR;
            end else begin : g_rest
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    assign intr_s = sync_q[SYNC_STAGES-1];

    // Shift the synchroniser chain every clock
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    // An acknowledge only counts as an interrupt entry when we are not
    // already inside a service routine; a repeated ack inside the ISR must
    // not clobber the saved flags or the pending request.
    assign ack_live = INT_ACK && (state_q == ST_IDLE);

    // ------------------------------------------------------------------
    // Request source: pending latch (edge mode) or synchronised level.
    // ------------------------------------------------------------------
`ifdef RAT_INT_EDGE_EN
    logic intr_prev_q;
    logic pend_q, pend_d;
    logic intr_rise;

    assign intr_rise = intr_s && !intr_prev_q;

    // A new rising edge beats a simultaneous acknowledge so the fresh request survives
    always_comb begin
        pend_d = pend_q;
        if (intr_rise) begin
            pend_d = 1'b1;
        end else if (ack_live) begin
            pend_d = 1'b0;
        end
    end

    // Remember the previous synchronised level and hold the pending latch
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            intr_prev_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            intr_prev_q <= intr_s;
            pend_q      <= pend_d;
        end
    end

    assign req_src = pend_q;
`else
    assign req_src = intr_s;
`endif

    // ------------------------------------------------------------------
    // Flag next-state logic.
    // ------------------------------------------------------------------

    // Carry: CLC beats SEC beats restore beats ALU load
    always_comb begin
        c_d = c_q;
        if (FLG_C_CLR) begin
            c_d = 1'b0;
        end else if (FLG_C_SET) begin
            c_d = 1'b1;
        end else if (FLG_RESTORE) begin
            c_d = sh_c_q;
        end else if (FLG_C_LD) begin
            c_d = C_IN;
        end
    end

    // Zero: restore beats ALU load
    always_comb begin
        z_d = z_q;
        if (FLG_RESTORE) begin
            z_d = sh_z_q;
        end else if (FLG_Z_LD) begin
            z_d = Z_IN;
        end
    end

    // Interrupt enable: any acknowledge masks further interrupts, CLI beats SEI
    always_comb begin
        i_d = i_q;
        if (INT_ACK) begin
            i_d = 1'b0;
        end else if (I_CLR) begin
            i_d = 1'b0;
        end else if (I_SET) begin
            i_d = 1'b1;
        end
    end

    // Shadows capture the pre-edge live flags on interrupt entry only
    always_comb begin
        sh_c_d = sh_c_q;
        sh_z_d = sh_z_q;
        if (ack_live) begin
            sh_c_d = c_q;
            sh_z_d = z_q;
        end
    end

    // Request is suppressed during the ack cycle so it is low right after entry
    always_comb begin
        int_req_d = req_src && i_q && !INT_ACK;
    end

    // Entry/exit tracking; restore outside an ISR is a plain software restore
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (int_req_q && INT_ACK) begin
                    state_d = ST_IN_ISR;
                end
            end
            ST_IN_ISR: begin
                if (FLG_RESTORE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register all flag, shadow, request and state bits
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            i_q       <= 1'b0;
            sh_c_q    <= 1'b0;
            sh_z_q    <= 1'b0;
            int_req_q <= 1'b0;
            state_q   <= ST_IDLE;
        end else begin
            c_q       <= c_d;
            z_q       <= z_d;
            i_q       <= i_d;
            sh_c_q    <= sh_c_d;
            sh_z_q    <= sh_z_d;
            int_req_q <= int_req_d;
            state_q   <= state_d;
        end
    end

    // Outputs come straight from flops; C_FLAG is the ALU carry-in
    assign C_FLAG  = c_q;
    assign Z_FLAG  = z_q;
    assign I_FLAG  = i_q;
    assign INT_REQ = int_req_q;

endmodule

// File: doc/rat_flag_unit.md
Name: rat_flag_unit

Overview:
Status-flag and interrupt-gating block for the RAT CPU, at the consuming end of the ALU flag interface. It registers the ALU's C and Z outputs under control-unit load strobes and returns the carry flag as the ALU carry-in. It also holds the interrupt-enable flag and the C/Z shadow copies saved on interrupt entry. It synchronises the external interrupt line and presents a gated interrupt request to the control unit.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages on INTR before use (legal range 2..4).

Ports:
CLK  in  1  system clock; all state updates on rising edge.
RST_N  in  1  asynchronous active-low reset.
C_IN  in  1  carry result from the ALU.
Z_IN  in  1  zero result from the ALU.
FLG_C_LD  in  1  load C_FLAG from C_IN.
FLG_Z_LD  in  1  load Z_FLAG from Z_IN.
FLG_C_SET  in  1  force C_FLAG to 1 (SEC).
FLG_C_CLR  in  1  force C_FLAG to 0 (CLC).
FLG_RESTORE  in  1  copy shadow C/Z into C_FLAG/Z_FLAG (RETIE/RETID).
I_SET  in  1  set I_FLAG (SEI, RETIE).
I_CLR  in  1  clear I_FLAG (CLI, RETID).
INT_ACK  in  1  control unit has entered its interrupt state.
INTR  in  1  external interrupt request, asynchronous to CLK.
C_FLAG  out  1  registered carry flag; also drives the ALU CIN.
Z_FLAG  out  1  registered zero flag.
I_FLAG  out  1  interrupt-enable flag.
INT_REQ  out  1  interrupt request to the control unit.

Behaviour:
- Reset (RST_N low, asynchronous): C_FLAG=0, Z_FLAG=0, I_FLAG=0, shadow C/Z=0, synchroniser=0, pending=0, INT_REQ=0. Takes effect immediately, including mid-sequence. No state survives reset.
- C_FLAG next-value priority, highest first: FLG_C_CLR -> 0; FLG_C_SET -> 1; FLG_RESTORE -> shadow C; FLG_C_LD -> C_IN; otherwise hold.
- Z_FLAG next-value priority: FLG_RESTORE -> shadow Z; FLG_Z_LD -> Z_IN; otherwise hold.
- I_FLAG next-value priority: INT_ACK -> 0; I_CLR -> 0; I_SET -> 1; otherwise hold.
- Shadow C/Z: on INT_ACK, capture the current registered C_FLAG/Z_FLAG (the pre-edge values). A coincident FLG_*_LD still updates the live flags in the same cycle. No other event writes the shadow.
- Latency: every flag is visible on its output one cycle after the strobe edge. C_FLAG feeds the ALU CIN with no combinational path from C_IN.
- Interrupt path: INTR passes through SYNC_STAGES flops, producing intr_s.
- Pending flag (edge mode): set on a rising edge of intr_s; cleared on INT_ACK.
  - If a rise and INT_ACK land in the same cycle, the rise wins and pending stays 1 (the new request is not lost).
  - While I_FLAG=0, pending is retained, so a masked interrupt fires after SEI.
- INT_REQ = pending AND I_FLAG, registered one cycle behind.
  - Falls in the cycle after INT_ACK, because I_FLAG is cleared.
  - Must never be 1 in the cycle following INT_ACK.
- Interrupt-entry state machine: IDLE -> (INT_REQ & INT_ACK) -> IN_ISR -> (FLG_RESTORE) -> IDLE.
  - INT_ACK received in IN_ISR is ignored: no shadow overwrite, pending untouched.
  - FLG_RESTORE received in IDLE still restores the flags (software use) and leaves the state at IDLE.

Optional Feature:
Macro RAT_INT_EDGE_EN.
- Defined: edge-triggered pending latch as described in Behaviour.
- Undefined: level mode. No pending latch; INT_REQ = intr_s AND I_FLAG, registered. A request is dropped if INTR deasserts before I_FLAG is set.

Test Plan:
- Reset mid-operation: set C=1, Z=1, I=1, then pull RST_N low asynchronously -> all outputs 0 within the same cycle, before the next CLK edge.
- Flag loads: C_IN=1, Z_IN=0 with FLG_C_LD=1, FLG_Z_LD=1 -> next cycle C_FLAG=1, Z_FLAG=0. Then FLG_C_SET=1 and FLG_C_CLR=1 together -> C_FLAG=0.
- Interrupt entry/exit: C=1, Z=1, I=1, INTR pulse -> INT_REQ=1 after SYNC_STAGES+2 cycles. INT_ACK with FLG_C_LD (C_IN=0) -> C_FLAG=0, I_FLAG=0, shadow=(1,1). FLG_RESTORE+I_SET -> C=1, Z=1, I=1, state IDLE.
- Masked interrupt (edge mode): I=0, INTR pulse of 1 cycle -> INT_REQ stays 0. I_SET -> INT_REQ=1 two cycles later.
- Collision: new rising edge on intr_s in the same cycle as INT_ACK -> pending=1 after the edge. INT_REQ=1 again once RETIE sets I_FLAG.
- Level mode (macro undefined): I=1, INTR held 1 -> INT_REQ=1. INTR released before ack -> INT_REQ returns to 0 with no pending retained.
